// File: rtl/ln_pkg.sv
// Shared definitions for the layer-norm datapath.
//   - sample / statistics widths
//   - alpha compression thresholds and the helper that picks alpha
//   - Stage1 FSM state encoding
package ln_pkg;

    localparam int XW      = 9;
    localparam int EX_W    = 22;
    localparam int EX2_W   = 32;
    localparam int ALPHA_W = 2;
    localparam int INVN_W  = 8;
    localparam int SQ_W    = 16;

    // One bit wider than a sample so 256 is representable as a threshold.
    localparam logic [XW:0] ALPHA_TH0 = (XW+1)'(64);
    localparam logic [XW:0] ALPHA_TH1 = (XW+1)'(128);
    localparam logic [XW:0] ALPHA_TH2 = (XW+1)'(256);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        SQUARE = 2'd1,
        REPLAY = 2'd2
    } s1_state_e;

    // Shift that keeps every compressed sample within [-64, 63], except
    // -256 which compresses to -32 with alpha=3.
    function automatic logic [ALPHA_W-1:0] alpha_of(input logic [XW-1:0] maxabs);
        logic [XW:0] m;
        m = {1'b0, maxabs};
        if (m < ALPHA_TH0)      alpha_of = 2'd0;
        else if (m < ALPHA_TH1) alpha_of = 2'd1;
        else if (m < ALPHA_TH2) alpha_of = 2'd2;
        else                    alpha_of = 2'd3;
    endfunction

endpackage

// File: rtl/stage1_buf.sv
// Sample buffer for Stage1: DEPTH x XW register array.
//   gclk   : clock
//   grst_n : synchronous active-low reset (clears the read register only)
//   we     : write enable, wdata stored at waddr
//   raddr  : read index, rdata registered one cycle later
module stage1_buf #(
    parameter int LOG2N = 3,
    parameter int XW    = 9
) (
    input  logic                 gclk,
    input  logic                 grst_n,
    input  logic                 we,
    input  logic [LOG2N-1:0]     waddr,
    input  logic [XW-1:0]        wdata,
    input  logic [LOG2N-1:0]     raddr,
    output logic signed [XW-1:0] rdata
);

    localparam int DEPTH = 2**LOG2N;

    logic [DEPTH-1:0][XW-1:0] mem;

    // Storage is never reset; contents are rewritten before each use.
    always_ff @(posedge gclk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge gclk) begin
        if (!grst_n) rdata <= '0;
        else         rdata <= mem[raddr];
    end

endmodule

// File: rtl/stage1_stats.sv
// Stage1 of the layer-norm datapath: buffers one vector of N samples,
// computes sum (Ex), compression shift (alpha) and compressed sum of squares
// (Ex2), then replays the samples to Stage2 with the statistics held.
//   i_clk/i_rstn       : clock, synchronous active-low reset
//   i_valid/i_x        : input sample stream, accepted while o_ready=1
//   o_valid/o_x_norm   : replayed samples, N consecutive cycles
//   o_Ex/o_Ex2/o_alpha : statistics, held until the next o_S1_done
//   o_inv_n            : constant 1/N in Q0.8
//   o_S1_done          : one-cycle pulse when statistics update
module stage1_stats
    import ln_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int XW    = ln_pkg::XW
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_valid,
    input  logic signed [XW-1:0]    i_x,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic signed [XW-1:0]    o_x_norm,
    output logic signed [EX_W-1:0]  o_Ex,
    output logic [EX2_W-1:0]        o_Ex2,
    output logic [ALPHA_W-1:0]      o_alpha,
    output logic [INVN_W-1:0]       o_inv_n,
    output logic                    o_S1_done
);

    localparam int N = 2**LOG2N;
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N-1);
    localparam logic [LOG2N:0]   SC_N     = (LOG2N+1)'(N);
    localparam logic [LOG2N:0]   SC_LAST  = (LOG2N+1)'(N+1);

    assign o_inv_n = INVN_W'(256 >> LOG2N);

    s1_state_e                state;
    logic [LOG2N-1:0]         cnt;      // write index during ACCUM
    logic [LOG2N:0]           sc;       // SQUARE cycle index, 0..N+1
    logic [LOG2N-1:0]         rc;       // REPLAY index
    logic signed [EX_W-1:0]   ex_acc;
    logic [EX2_W-1:0]         ex2_acc;
    logic [XW-1:0]            maxabs;
    logic [ALPHA_W-1:0]       alpha;

    logic                     accept;
    logic [XW-1:0]            absx;
    logic [XW-1:0]            maxabs_nxt;
    logic signed [EX_W-1:0]   x_ext;
    logic [LOG2N-1:0]         rd_idx;
    logic signed [XW-1:0]     rd_data;
    logic signed [XW-1:0]     xs;
    logic signed [SQ_W-1:0]   xs_ext;
    logic [SQ_W-1:0]          sq;

    // o_ready is registered, so it is also the acceptance qualifier.
    assign accept     = o_ready & i_valid;
    // Two's-complement negate in XW bits: -256 maps to the unsigned 256.
    assign absx       = i_x[XW-1] ? (~i_x + XW'(1)) : i_x;
    assign maxabs_nxt = (absx > maxabs) ? absx : maxabs;
    assign x_ext      = {{(EX_W-XW){i_x[XW-1]}}, i_x};

    // Read index runs one ahead of the consumer because the buffer read is
    // registered. At SQUARE's final cycle it points at element 0 so the
    // first replayed sample is ready at REPLAY entry.
    always_comb begin
        rd_idx = '0;
        case (state)
            SQUARE:  rd_idx = (sc < SC_N) ? sc[LOG2N-1:0] : '0;
            REPLAY:  rd_idx = rc + LOG2N'(1);
            default: rd_idx = '0;
        endcase
    end

    assign xs     = rd_data >>> alpha;
    assign xs_ext = {{(SQ_W-XW){xs[XW-1]}}, xs};
    assign sq     = SQ_W'(xs_ext * xs_ext);

    stage1_buf #(.LOG2N(LOG2N), .XW(XW)) u_buf (
        .gclk   (i_clk),
        .grst_n (i_rstn),
        .we     (accept),
        .waddr  (cnt),
        .wdata  (i_x),
        .raddr  (rd_idx),
        .rdata  (rd_data)
    );

    assign o_x_norm = rd_data;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state     <= ACCUM;
            cnt       <= '0;
            sc        <= '0;
            rc        <= '0;
            ex_acc    <= '0;
            ex2_acc   <= '0;
            maxabs    <= '0;
            alpha     <= '0;
            o_ready   <= 1'b0;
            o_valid   <= 1'b0;
            o_Ex      <= '0;
            o_Ex2     <= '0;
            o_alpha   <= '0;
            o_S1_done <= 1'b0;
        end else begin
            o_S1_done <= 1'b0;
            case (state)
                ACCUM: begin
                    o_ready <= 1'b1;
                    if (accept) begin
                        ex_acc <= ex_acc + x_ext;
                        maxabs <= maxabs_nxt;
                        cnt    <= cnt + LOG2N'(1);
                        if (cnt == CNT_LAST) begin
                            state   <= SQUARE;
                            alpha   <= alpha_of(maxabs_nxt);
                            sc      <= '0;
                            o_ready <= 1'b0;
                        end
                    end
                end
                SQUARE: begin
                    sc <= sc + (LOG2N+1)'(1);
                    // rd_data holds element sc-1 for sc in 1..N
                    if (sc != '0 && sc <= SC_N)
                        ex2_acc <= ex2_acc + EX2_W'(sq);
                    if (sc == SC_LAST) begin
                        state     <= REPLAY;
                        o_Ex      <= ex_acc;
                        o_Ex2     <= ex2_acc;
                        o_alpha   <= alpha;
                        o_S1_done <= 1'b1;
                        o_valid   <= 1'b1;
                        rc        <= '0;
                    end
                end
                REPLAY: begin
                    rc <= rc + LOG2N'(1);
                    if (rc == CNT_LAST) begin
                        state   <= ACCUM;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        cnt     <= '0;
                        ex_acc  <= '0;
                        ex2_acc <= '0;
                        maxabs  <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_stage1_stats.sv
module tb_stage1_stats;

    logic              i_clk = 1'b0;
    logic              i_rstn;
    logic              i_valid;
    logic signed [8:0] i_x;
    logic              o_ready;
    logic              o_valid;
    logic signed [8:0] o_x_norm;
    logic signed [21:0] o_Ex;
    logic [31:0]       o_Ex2;
    logic [1:0]        o_alpha;
    logic [7:0]        o_inv_n;
    logic              o_S1_done;

    always #5 i_clk = ~i_clk;

    stage1_stats #(.LOG2N(3), .XW(9)) dut (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_valid   (i_valid),
        .i_x       (i_x),
        .o_ready   (o_ready),
        .o_valid   (o_valid),
        .o_x_norm  (o_x_norm),
        .o_Ex      (o_Ex),
        .o_Ex2     (o_Ex2),
        .o_alpha   (o_alpha),
        .o_inv_n   (o_inv_n),
        .o_S1_done (o_S1_done)
    );

    typedef struct {
        logic [7:0][8:0] xs;
        bit              gaps;   // i_valid toggles 1,0,1,0...
        bit              hold;   // i_valid stays high through SQUARE/REPLAY
        int              ex;
        int              ex2;
        int              alpha;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int prev_ex = 0, prev_ex2 = 0, prev_alpha = 0;
    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7,
                                input bit gaps, input bit hold,
                                input int ex, input int ex2, input int alpha);
        vec_t v;
        int a[8];
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        for (int i = 0; i < 8; i++) v.xs[i] = 9'(a[i]);
        v.gaps = gaps; v.hold = hold;
        v.ex = ex; v.ex2 = ex2; v.alpha = alpha;
        return v;
    endfunction

    task automatic wait_ready();
        int g = 0;
        while (!o_ready && g < 100) begin
            @(posedge i_clk); #1; g++;
        end
        chk("ready_wait", int'(o_ready), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int  i = 0;
        int  g = 0;
        int  lat = 0;
        bit  ph = 1'b0;
        bit  acc;
        wait_ready();
        while (i < 8 && g < 200) begin
            if (v.gaps && ph) i_valid = 1'b0;
            else begin i_valid = 1'b1; i_x = v.xs[i]; end
            acc = i_valid && o_ready;
            ph = ~ph;
            @(posedge i_clk); #1; g++;
            if (acc) i++;
        end
        chk("samples_accepted", i, 8);
        // Edge k has just passed.
        i_valid = v.hold;
        i_x = 9'sh0AA;
        while (lat < 40) begin
            @(posedge i_clk); #1; lat++;
            if (lat == 1) begin
                chk("ready_in_square", int'(o_ready), 0);
                chk("hold_ex", int'($signed(o_Ex)), prev_ex);
                chk("hold_ex2", int'(o_Ex2), prev_ex2);
                chk("hold_alpha", int'(o_alpha), prev_alpha);
            end
            if (o_S1_done) break;
        end
        chk("done_latency", lat, 10);
        chk("ex", int'($signed(o_Ex)), v.ex);
        chk("ex2", int'(o_Ex2), v.ex2);
        chk("alpha", int'(o_alpha), v.alpha);
        chk("inv_n", int'(o_inv_n), 32);
        chk("valid0", int'(o_valid), 1);
        chk("xnorm0", int'(o_x_norm), int'($signed(v.xs[0])));
        for (int j = 1; j < 8; j++) begin
            if (j == 7) i_valid = 1'b0;
            @(posedge i_clk); #1;
            if (j == 1) chk("done_pulse", int'(o_S1_done), 0);
            if (j == 4) chk("ready_in_replay", int'(o_ready), 0);
            chk("valid_replay", int'(o_valid), 1);
            chk("xnorm", int'(o_x_norm), int'($signed(v.xs[j])));
        end
        @(posedge i_clk); #1;
        chk("valid_end", int'(o_valid), 0);
        chk("ready_end", int'(o_ready), 1);
        chk("ex_after", int'($signed(o_Ex)), v.ex);
        prev_ex = v.ex; prev_ex2 = v.ex2; prev_alpha = v.alpha;
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", int'(o_ready), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ex", int'($signed(o_Ex)), 0);
        chk("rst_ex2", int'(o_Ex2), 0);
        chk("rst_alpha", int'(o_alpha), 0);
        chk("rst_done", int'(o_S1_done), 0);
        chk("rst_xnorm", int'(o_x_norm), 0);
        chk("rst_inv_n", int'(o_inv_n), 32);
    endtask

    initial begin
        tbl[0] = mk(44, -81, -11, 64, -61, 123, 67, -25, 0, 0, 120, 9165, 1);
        tbl[1] = mk(-3, -3, -3, -3, -3, -3, -3, -3, 0, 0, -24, 72, 0);
        tbl[2] = mk(-256, 255, 255, 255, 255, 255, 255, 255, 0, 0, 1529, 7751, 3);
        tbl[3] = mk(44, -81, -11, 64, -61, 123, 67, -25, 1, 0, 120, 9165, 1);
        tbl[4] = mk(44, -81, -11, 64, -61, 123, 67, -25, 0, 1, 120, 9165, 1);
        tbl[5] = mk(10, 10, 10, 10, 10, 10, 10, 10, 0, 0, 80, 800, 0);

        i_rstn = 1'b0; i_valid = 1'b0; i_x = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk_reset_state();
        i_rstn = 1'b1;

        // Entries run back to back: each waits only for o_ready to return.
        for (int t = 0; t < 6; t++) run_vec(tbl[t]);

        // Abort a partially loaded vector with a one-edge reset.
        wait_ready();
        for (int s = 0; s < 5; s++) begin
            i_valid = 1'b1;
            i_x = (s == 1) ? -9'sd200 : 9'sd100;
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        i_rstn = 1'b0;
        @(posedge i_clk); #1;
        chk_reset_state();
        i_rstn = 1'b1;
        prev_ex = 0; prev_ex2 = 0; prev_alpha = 0;
        run_vec(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
